// File: rtl/adder_pkg.sv
// Shared defaults and helpers for the pipelined ripple-carry adder.
// Holds the slice-width legality function and the stage record layout.
package adder_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    // Returns 0 for an illegal WIDTH/STAGES pairing.
    function automatic int slice_width(input int width, input int stages);
        if (width < 1 || stages < 1 || stages > width) begin
            return 0;
        end
        if ((width % stages) != 0) begin
            return 0;
        end
        return width / stages;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic [DEF_WIDTH-1:0] sum_lo;
        logic [DEF_WIDTH-1:0] a_hi;
        logic [DEF_WIDTH-1:0] b_hi;
    } stage_rec_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell used to build the ripple slices.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_pipe_slice.sv
// Combinational W-bit ripple-carry slice made of full-adder cells.
module rca_pipe_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_s,
    output logic         o_cout
);

    logic [W:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a    (i_a[i]),
            .b    (i_b[i]),
            .cin  (w_c[i]),
            .s    (o_s[i]),
            .cout (w_c[i+1])
        );
    end

    assign o_cout = w_c[W];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder with valid/ready handshake.
// Define PIPELINED_RIPPLE_ADDER_OVF_EN to add the OVF output.
module pipelined_ripple_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int SLICE = slice_width(WIDTH, STAGES);

    if (SLICE == 0) begin : g_bad_cfg
        $error("pipelined_ripple_adder: WIDTH must be a multiple of STAGES");
    end

    logic w_adv;

    assign w_adv    = ~rst & (~out_valid | out_ready);
    assign in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int HI = WIDTH - (k + 1) * SLICE;

        // Operand bits not yet added, lowest slice first.
        logic [HI+SLICE-1:0]    w_ain;
        logic [HI+SLICE-1:0]    w_bin;
        logic                   w_cin;
        logic                   w_vin;
        logic [SLICE-1:0]       w_s;
        logic                   w_cout;
        logic [(k+1)*SLICE-1:0] w_sum_nx;

        logic                   r_valid;
        logic                   r_carry;
        logic [(k+1)*SLICE-1:0] r_sum;

        if (k == 0) begin : g_head
            assign w_ain    = A;
            assign w_bin    = B;
            assign w_cin    = Cin;
            assign w_vin    = in_valid;
            assign w_sum_nx = w_s;
        end else begin : g_body
            assign w_ain    = g_st[k-1].g_hi.r_a;
            assign w_bin    = g_st[k-1].g_hi.r_b;
            assign w_cin    = g_st[k-1].r_carry;
            assign w_vin    = g_st[k-1].r_valid;
            assign w_sum_nx = {w_s, g_st[k-1].r_sum};
        end

        rca_pipe_slice #(
            .W (SLICE)
        ) u_slice (
            .i_a    (w_ain[SLICE-1:0]),
            .i_b    (w_bin[SLICE-1:0]),
            .i_cin  (w_cin),
            .o_s    (w_s),
            .o_cout (w_cout)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_sum   <= '0;
            end else if (w_adv) begin
                r_valid <= w_vin;
                r_carry <= w_cout;
                r_sum   <= w_sum_nx;
            end
        end

        if (HI > 0) begin : g_hi
            logic [HI-1:0] r_a;
            logic [HI-1:0] r_b;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_ain[HI+SLICE-1:SLICE];
                    r_b <= w_bin[HI+SLICE-1:SLICE];
                end
            end
        end

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic r_ovf;

            // a^b^s at the MSB recovers the carry into the MSB.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_ain[SLICE-1] ^ w_bin[SLICE-1]
                           ^ w_s[SLICE-1] ^ w_cout;
                end
            end
        end
`endif
    end

    assign out_valid = g_st[STAGES-1].r_valid;
    assign S         = g_st[STAGES-1].r_sum;
    assign Cout      = g_st[STAGES-1].r_carry;

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    assign OVF = g_st[STAGES-1].g_ovf.r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench: 16/4 pipe with scoreboard plus a 4/1 instance.
module tb_pipelined_ripple_adder;

    localparam int W  = 16;
    localparam int ST = 4;
    localparam int NV = 12;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         cout;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         Cout;

    logic         s_in_valid;
    logic         s_in_ready;
    logic [3:0]   s_A;
    logic [3:0]   s_B;
    logic         s_Cin;
    logic         s_out_valid;
    logic         s_out_ready;
    logic [3:0]   s_S;
    logic         s_Cout;

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    logic         OVF;
    logic         s_OVF;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t sbq[$];
    vec_t tv[NV];

    pipelined_ripple_adder #(
        .WIDTH  (W),
        .STAGES (ST)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout)
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
        ,
        .OVF       (OVF)
`endif
    );

    pipelined_ripple_adder #(
        .WIDTH  (4),
        .STAGES (1)
    ) u_small (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .A         (s_A),
        .B         (s_B),
        .Cin       (s_Cin),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .S         (s_S),
        .Cout      (s_Cout)
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
        ,
        .OVF       (s_OVF)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Completion happens at the next edge when out_valid & out_ready.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sbq.delete();
            end else if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_S", 32'(S), 32'(e.s));
                    chk("sb_Cout", 32'(Cout), 32'(e.c));
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
                    chk("sb_OVF", 32'(OVF), 32'(e.v));
`endif
                end
            end
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] es,
                        input logic ec);
        exp_t e;
        int   n;
        A        = a;
        B        = b;
        Cin      = cin;
        in_valid = 1'b1;
        n        = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        e.s = es;
        e.c = ec;
        e.v = (a[W-1] == b[W-1]) && (es[W-1] != a[W-1]);
        sbq.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(sbq.size()), 32'd0);
        tick();
    endtask

    initial begin
        logic [W:0] t;
        int         lat;

        tv[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tv[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        tv[2] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        tv[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        tv[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        tv[5] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
        for (int i = 6; i < NV; i++) begin
            tv[i].a   = W'($urandom);
            tv[i].b   = W'($urandom);
            tv[i].cin = 1'($urandom_range(0, 1));
            t = {1'b0, tv[i].a} + {1'b0, tv[i].b} + {16'd0, tv[i].cin};
            tv[i].s    = t[W-1:0];
            tv[i].cout = t[W];
        end

        rst         = 1'b1;
        in_valid    = 1'b0;
        A           = '0;
        B           = '0;
        Cin         = 1'b0;
        out_ready   = 1'b1;
        s_in_valid  = 1'b0;
        s_A         = '0;
        s_B         = '0;
        s_Cin       = 1'b0;
        s_out_ready = 1'b1;

        fork
            monitor();
        join_none

        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_Cout", 32'(Cout), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Carry ripples through every stage.
        send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'(ST));
        chk("lat_S", 32'(S), 32'h0000);
        chk("lat_Cout", 32'(Cout), 32'd1);
        drain();

        for (int i = 0; i < NV; i++) begin
            send(tv[i].a, tv[i].b, tv[i].cin, tv[i].s, tv[i].cout);
            if (i >= ST - 1) begin
                chk("b2b_valid", 32'(out_valid), 32'd1);
            end
        end
        for (int j = 0; j < ST - 1; j++) begin
            tick();
            chk("b2b_tail_valid", 32'(out_valid), 32'd1);
        end
        tick();
        chk("b2b_idle", 32'(out_valid), 32'd0);
        drain();

        // Fill the pipe under backpressure, then release.
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0);
        send(16'hF000, 16'h1000, 1'b1, 16'h0001, 1'b1);
        send(16'hABCD, 16'h0000, 1'b1, 16'hABCE, 1'b0);
        send(16'h7FFF, 16'h7FFF, 1'b0, 16'hFFFE, 1'b0);
        A        = 16'h0010;
        B        = 16'h0020;
        Cin      = 1'b0;
        in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_S", 32'(S), 32'h3333);
            chk("stall_Cout", 32'(Cout), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        sbq.push_back('{16'h0030, 1'b0, 1'b0});
        tick();
        in_valid = 1'b0;
        drain();

        // Reset with three ops in flight.
        send(16'h0101, 16'h0101, 1'b0, 16'h0202, 1'b0);
        send(16'h0303, 16'h0101, 1'b0, 16'h0404, 1'b0);
        send(16'h0505, 16'h0101, 1'b0, 16'h0606, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("midrst_idle", 32'(out_valid), 32'd0);
        end
        send(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);
        drain();

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
        send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
        drain();
        send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        drain();
`endif

        // Degenerate single-stage instance.
        s_A        = 4'b1001;
        s_B        = 4'b0111;
        s_Cin      = 1'b1;
        s_in_valid = 1'b1;
        chk("small_pre_valid", 32'(s_out_valid), 32'd0);
        chk("small_in_ready", 32'(s_in_ready), 32'd1);
        tick();
        s_A   = 4'hF;
        s_B   = 4'h0;
        s_Cin = 1'b1;
        chk("small_valid", 32'(s_out_valid), 32'd1);
        chk("small_S", 32'(s_S), 32'h1);
        chk("small_Cout", 32'(s_Cout), 32'd1);
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
        chk("small_OVF", 32'(s_OVF), 32'd0);
`endif
        tick();
        s_in_valid = 1'b0;
        chk("small2_valid", 32'(s_out_valid), 32'd1);
        chk("small2_S", 32'(s_S), 32'h0);
        chk("small2_Cout", 32'(s_Cout), 32'd1);
        tick();
        chk("small_idle", 32'(s_out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
